// File: rtl/vram_arbiter.sv
// vram_arbiter: single-port frame-buffer arbiter.
// Scan-out fetches always win and see a fixed 3-cycle read latency. Leftover
// slots alternate between the pixel writer and the readback reader. A one-hot
// tag rides a two-stage pipeline next to the RAM command so returning data can
// be steered to the right consumer.
module vram_arbiter #(
  parameter int ADDR_W        = 17,
  parameter int DATA_W        = 12,
  parameter bit WR_BLANK_ONLY = 1'b0
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              blank,
  input  logic              pix_req,
  input  logic [ADDR_W-1:0] pix_addr,
  output logic              pix_valid,
  output logic [DATA_W-1:0] pix_data,
  input  logic              wr_req,
  input  logic [ADDR_W-1:0] wr_addr,
  input  logic [DATA_W-1:0] wr_data,
  output logic              wr_gnt,
  input  logic              rd_req,
  input  logic [ADDR_W-1:0] rd_addr,
  output logic              rd_gnt,
  output logic              rd_valid,
  output logic [DATA_W-1:0] rd_data,
  output logic              ram_en,
  output logic              ram_we,
  output logic [ADDR_W-1:0] ram_addr,
  output logic [DATA_W-1:0] ram_wdata,
  input  logic [DATA_W-1:0] ram_rdata
);

  localparam int         TAG_W    = 3;
  localparam logic [2:0] TAG_NONE = 3'b001;
  localparam logic [2:0] TAG_RD   = 3'b010;
  localparam logic [2:0] TAG_PIX  = 3'b100;

  logic             wr_elig;
  logic             pix_sel;
  logic             wr_sel;
  logic             rd_sel;
  logic             last_wr;
  logic [TAG_W-1:0] tag_p0;
  logic [TAG_W-1:0] tag_p1;

  // Pick at most one requester per cycle: scan-out first, then round-robin.
  always_comb begin
    wr_elig = wr_req && (!WR_BLANK_ONLY || blank);
    pix_sel = 1'b0;
    wr_sel  = 1'b0;
    rd_sel  = 1'b0;
    if (!rst) begin
      if (pix_req) begin
        pix_sel = 1'b1;
      end else if (wr_elig && rd_req) begin
        wr_sel = !last_wr;
        rd_sel = last_wr;
      end else begin
        wr_sel = wr_elig;
        rd_sel = rd_req;
      end
    end
  end

  assign wr_gnt = wr_sel;
  assign rd_gnt = rd_sel;

  // Round-robin pointer only moves on writer/reader grants, never on fetches.
  always_ff @(posedge clk) begin
    if (rst) begin
      last_wr <= 1'b0;
    end else if (wr_sel) begin
      last_wr <= 1'b1;
    end else if (rd_sel) begin
      last_wr <= 1'b0;
    end
  end

  // ---- stage p0: registered RAM command and its routing tag ----
  // Register the winning command onto the RAM port.
  always_ff @(posedge clk) begin
    if (rst) begin
      ram_en    <= 1'b0;
      ram_we    <= 1'b0;
      ram_addr  <= '0;
      ram_wdata <= '0;
      tag_p0    <= TAG_NONE;
    end else begin
      ram_en <= pix_sel || wr_sel || rd_sel;
      ram_we <= wr_sel;
      if (pix_sel) begin
        ram_addr <= pix_addr;
      end else if (wr_sel) begin
        ram_addr  <= wr_addr;
        ram_wdata <= wr_data;
      end else if (rd_sel) begin
        ram_addr <= rd_addr;
      end
      if (pix_sel) begin
        tag_p0 <= TAG_PIX;
      end else if (rd_sel) begin
        tag_p0 <= TAG_RD;
      end else begin
        tag_p0 <= TAG_NONE;
      end
    end
  end

  // ---- stage p1: tag aligned with ram_rdata ----
  // Delay the tag by the RAM's one-cycle read latency; reset drops in-flight reads.
  always_ff @(posedge clk) begin
    if (rst) begin
      tag_p1 <= TAG_NONE;
    end else begin
      tag_p1 <= tag_p0;
    end
  end

  // ---- stage p2: steer returned data to its consumer ----
  // Capture read data for whichever consumer the tag names; data holds otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      pix_valid <= 1'b0;
      rd_valid  <= 1'b0;
      pix_data  <= '0;
      rd_data   <= '0;
    end else begin
      pix_valid <= 1'b0;
      rd_valid  <= 1'b0;
      case (tag_p1)
        TAG_PIX: begin
          pix_valid <= 1'b1;
          pix_data  <= ram_rdata;
        end
        TAG_RD: begin
          rd_valid <= 1'b1;
          rd_data  <= ram_rdata;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
// tb_vram_arbiter: randomized + directed bench for vram_arbiter.
// A reference model computes grants from the arbitration rules, keeps its own
// picture of memory contents, and queues the expected RAM commands and read
// responses with their due cycle; a monitor pops and compares them.
module tb_vram_arbiter;
  localparam int AW  = 17;
  localparam int DW  = 12;
  localparam bit WBO = 1'b1;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          blank = 1'b1;
  logic          pix_req = 1'b0;
  logic [AW-1:0] pix_addr = '0;
  logic          wr_req = 1'b0;
  logic [AW-1:0] wr_addr = '0;
  logic [DW-1:0] wr_data = '0;
  logic          rd_req = 1'b0;
  logic [AW-1:0] rd_addr = '0;
  logic [DW-1:0] ram_rdata = '0;
  logic          pix_valid, wr_gnt, rd_gnt, rd_valid, ram_en, ram_we;
  logic [DW-1:0] pix_data, rd_data, ram_wdata;
  logic [AW-1:0] ram_addr;

  always #5 clk = ~clk;

  vram_arbiter #(.ADDR_W(AW), .DATA_W(DW), .WR_BLANK_ONLY(WBO)) dut (
    .clk(clk), .rst(rst), .blank(blank),
    .pix_req(pix_req), .pix_addr(pix_addr), .pix_valid(pix_valid), .pix_data(pix_data),
    .wr_req(wr_req), .wr_addr(wr_addr), .wr_data(wr_data), .wr_gnt(wr_gnt),
    .rd_req(rd_req), .rd_addr(rd_addr), .rd_gnt(rd_gnt), .rd_valid(rd_valid), .rd_data(rd_data),
    .ram_en(ram_en), .ram_we(ram_we), .ram_addr(ram_addr), .ram_wdata(ram_wdata),
    .ram_rdata(ram_rdata)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s cyc=%0d actual=%0h required=%0h", name, cyc, act, exp);
    end
  endtask

  function automatic logic [DW-1:0] init_val(input logic [AW-1:0] a);
    return a[DW-1:0] ^ 12'h5A3;
  endfunction

  // Environment RAM: synchronous, write-first, one-cycle read latency.
  logic [DW-1:0] ram_mem [logic [AW-1:0]];
  always @(posedge clk) begin
    if (ram_en) begin
      if (ram_we) begin
        ram_mem[ram_addr] = ram_wdata;
        ram_rdata <= ram_wdata;
      end else begin
        ram_rdata <= ram_mem.exists(ram_addr) ? ram_mem[ram_addr] : init_val(ram_addr);
      end
    end
  end

  // Reference model state.
  logic [DW-1:0] ref_mem [logic [AW-1:0]];
  bit ref_wr_last = 1'b0;

  typedef struct { int due; bit we; logic [AW-1:0] addr; logic [DW-1:0] data; } cmd_t;
  typedef struct { int due; bit pix; logic [DW-1:0] data; } rsp_t;
  cmd_t cmd_q[$];
  rsp_t rsp_q[$];

  function automatic logic [DW-1:0] ref_get(input logic [AW-1:0] a);
    return ref_mem.exists(a) ? ref_mem[a] : init_val(a);
  endfunction

  // Model: decide the grant from the rules, check it, queue expected effects.
  always @(negedge clk) begin : model
    bit ep, ew, er, w_ok;
    ep = 1'b0; ew = 1'b0; er = 1'b0;
    if (rst) begin
      ref_wr_last = 1'b0;
      while (rsp_q.size() > 0 && rsp_q[$].due > cyc) void'(rsp_q.pop_back());
    end else if (pix_req) begin
      ep = 1'b1;
    end else begin
      w_ok = wr_req && (!WBO || blank);
      if (w_ok && rd_req) begin
        ew = !ref_wr_last;
        er = ref_wr_last;
      end else begin
        ew = w_ok;
        er = rd_req;
      end
    end
    chk("wr_gnt", 32'(wr_gnt), 32'(ew));
    chk("rd_gnt", 32'(rd_gnt), 32'(er));
    if (ep) begin
      cmd_q.push_back('{cyc + 1, 1'b0, pix_addr, '0});
      rsp_q.push_back('{cyc + 3, 1'b1, ref_get(pix_addr)});
    end
    if (ew) begin
      ref_mem[wr_addr] = wr_data;
      cmd_q.push_back('{cyc + 1, 1'b1, wr_addr, wr_data});
      ref_wr_last = 1'b1;
    end
    if (er) begin
      cmd_q.push_back('{cyc + 1, 1'b0, rd_addr, '0});
      rsp_q.push_back('{cyc + 3, 1'b0, ref_get(rd_addr)});
      ref_wr_last = 1'b0;
    end
  end

  // Monitor: compare RAM port and read-return outputs against queued expectations.
  logic [DW-1:0] exp_pix_data = '0;
  logic [DW-1:0] exp_rd_data = '0;
  always @(negedge clk) begin : monitor
    bit ee, ev_p, ev_r;
    cmd_t c;
    rsp_t r;
    ee = 1'b0; ev_p = 1'b0; ev_r = 1'b0;
    c = '{0, 1'b0, '0, '0};
    if (cmd_q.size() > 0 && cmd_q[0].due == cyc) begin
      c = cmd_q.pop_front();
      ee = 1'b1;
    end
    chk("ram_en", 32'(ram_en), 32'(ee));
    if (ee) begin
      chk("ram_we", 32'(ram_we), 32'(c.we));
      chk("ram_addr", 32'(ram_addr), 32'(c.addr));
      if (c.we) chk("ram_wdata", 32'(ram_wdata), 32'(c.data));
    end
    if (rsp_q.size() > 0 && rsp_q[0].due == cyc) begin
      r = rsp_q.pop_front();
      if (r.pix) begin
        ev_p = 1'b1;
        exp_pix_data = r.data;
      end else begin
        ev_r = 1'b1;
        exp_rd_data = r.data;
      end
    end
    chk("pix_valid", 32'(pix_valid), 32'(ev_p));
    chk("rd_valid", 32'(rd_valid), 32'(ev_r));
    chk("pix_data", 32'(pix_data), 32'(exp_pix_data));
    chk("rd_data", 32'(rd_data), 32'(exp_rd_data));
    if (rst) begin
      exp_pix_data = '0;
      exp_rd_data = '0;
    end
  end

  // One bus cycle: drive inputs just after the edge, report grants at mid-cycle.
  task automatic drive(input bit rs, input bit bl,
                       input bit pr, input logic [AW-1:0] pa,
                       input bit wq, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                       input bit rq, input logic [AW-1:0] ra,
                       output bit gw, output bit gr);
    @(posedge clk);
    #1;
    rst = rs; blank = bl;
    pix_req = pr; pix_addr = pa;
    wr_req = wq; wr_addr = wa; wr_data = wd;
    rd_req = rq; rd_addr = ra;
    @(negedge clk);
    gw = wr_gnt;
    gr = rd_gnt;
  endtask

  initial begin
    bit gw, gr, wp, rp, bl, pr, rs;
    logic [AW-1:0] wa, ra, pa;
    logic [DW-1:0] wd;

    ram_mem[17'h00123] = 12'hABC;
    ref_mem[17'h00123] = 12'hABC;

    // Reset held 100 ns with every request asserted.
    for (int i = 0; i < 10; i++)
      drive(1, 1, 1, 17'h7, 1, 17'h8, 12'h111, 1, 17'h9, gw, gr);
    chk("rst_ram_addr", 32'(ram_addr), 32'h0);
    chk("rst_ram_wdata", 32'(ram_wdata), 32'h0);

    // First tie after release, then round-robin over 6 cycles.
    for (int i = 0; i < 6; i++)
      drive(0, 1, 0, '0, 1, AW'(16 + i), DW'(12'h300 + i), 1, AW'(16 + i), gw, gr);
    drive(0, 1, 0, '0, 0, '0, '0, 0, '0, gw, gr);

    // Pixel fetch latency.
    drive(0, 1, 1, 17'h00123, 0, '0, '0, 0, '0, gw, gr);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, '0, 0, '0, '0, 0, '0, gw, gr);

    // Priority: pixel beats both, then writer, then reader.
    drive(0, 1, 1, 17'h00123, 1, 17'h4, 12'h444, 1, 17'h5, gw, gr);
    drive(0, 1, 0, '0, 1, 17'h4, 12'h444, 1, 17'h5, gw, gr);
    drive(0, 1, 0, '0, 0, '0, '0, 1, 17'h5, gw, gr);
    for (int i = 0; i < 4; i++) drive(0, 1, 0, '0, 0, '0, '0, 0, '0, gw, gr);

    // Blank gating: no write grant during active video, grant when blank rises.
    for (int i = 0; i < 10; i++) drive(0, 0, 0, '0, 1, 17'h6, 12'h666, 0, '0, gw, gr);
    drive(0, 1, 0, '0, 1, 17'h6, 12'h666, 0, '0, gw, gr);
    for (int i = 0; i < 3; i++) drive(0, 1, 0, '0, 0, '0, '0, 0, '0, gw, gr);

    // Reset one cycle after a read grant: its data must never emerge.
    drive(0, 1, 0, '0, 0, '0, '0, 1, 17'h6, gw, gr);
    drive(1, 1, 0, '0, 0, '0, '0, 0, '0, gw, gr);
    for (int i = 0; i < 5; i++) drive(0, 1, 0, '0, 0, '0, '0, 0, '0, gw, gr);

    // Randomized traffic honouring the hold-until-granted handshake.
    wp = 0; rp = 0; bl = 1; gw = 0; gr = 0;
    wa = '0; ra = '0; wd = '0;
    for (int i = 0; i < 3000; i++) begin
      if (!wp || gw) begin
        wp = ($urandom_range(0, 2) == 0);
        wa = AW'($urandom_range(0, 15));
        wd = DW'($urandom);
      end
      if (!rp || gr) begin
        rp = ($urandom_range(0, 2) == 0);
        ra = AW'($urandom_range(0, 15));
      end
      if ($urandom_range(0, 7) == 0) bl = !bl;
      pr = ($urandom_range(0, 3) == 0);
      pa = ($urandom_range(0, 7) == 0) ? 17'h00123 : AW'($urandom_range(0, 15));
      rs = ($urandom_range(0, 299) == 0);
      drive(rs, bl, pr, pa, wp, wa, wd, rp, ra, gw, gr);
    end

    // Drain and confirm every expectation was consumed.
    for (int i = 0; i < 6; i++) drive(0, 1, 0, '0, 0, '0, '0, 0, '0, gw, gr);
    chk("drain", 32'(rsp_q.size() + cmd_q.size()), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/vram_arbiter.md
# vram_arbiter

Single-port video-RAM arbiter sitting between the VGA scan-out path, the game-logic pixel writer and a debug/readback reader in the `top` design, all on the 100 MHz `clk`. Scan-out fetches have absolute priority and a fixed, guaranteed latency, so the display never tears or stalls. Leftover RAM slots are shared round-robin between writer and reader. Writes can optionally be confined to blanking intervals.

## Interface
Parameters:
- `ADDR_W`, 17: frame-buffer word address width (320×240 = 76800 words).
- `DATA_W`, 12: pixel width (4:4:4 RGB, matches `vga_r/g/b`).
- `WR_BLANK_ONLY`, 0: when 1, writer grants are issued only while `blank` = 1.

Ports:
- `clk`  in  1  100 MHz system clock; all logic on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `blank`  in  1  from VGA timing generator: 1 during horizontal or vertical blanking.
- `pix_req`  in  1  one-cycle scan-out fetch strobe.
- `pix_addr`  in  ADDR_W  fetch address, valid with `pix_req`.
- `pix_valid`  out  1  fetched pixel valid.
- `pix_data`  out  DATA_W  fetched pixel.
- `wr_req`  in  1  write request; held until granted.
- `wr_addr`  in  ADDR_W  write address, stable while `wr_req`.
- `wr_data`  in  DATA_W  write data, stable while `wr_req`.
- `wr_gnt`  out  1  combinational; write accepted this cycle.
- `rd_req`  in  1  readback request; held until granted.
- `rd_addr`  in  ADDR_W  readback address, stable while `rd_req`.
- `rd_gnt`  out  1  combinational; read accepted this cycle.
- `rd_valid`  out  1  readback data valid.
- `rd_data`  out  DATA_W  readback data.
- `ram_en`  out  1  registered RAM enable.
- `ram_we`  out  1  registered RAM write enable.
- `ram_addr`  out  ADDR_W  registered RAM address.
- `ram_wdata`  out  DATA_W  registered RAM write data.
- `ram_rdata`  in  DATA_W  RAM read data, valid one cycle after `ram_en` with `ram_we` = 0.

## Operation
- One RAM access per cycle. Arbitration in cycle t selects at most one of {pixel, write, read}:
  - `pix_req` = 1: pixel wins; `wr_gnt` = `rd_gnt` = 0.
  - Otherwise, eligible writer = `wr_req` && (!WR_BLANK_ONLY || `blank`). Eligible reader = `rd_req`.
  - Only one eligible: grant it.
  - Both eligible: grant the one not served last; round-robin pointer `last_wr` (1 bit) updates only on a write or read grant.
- Requester handshake: a request is accepted in the cycle its `gnt` is 1. Requester may drop or change `req`/`addr`/`data` in the next cycle.
- A one-hot tag per accepted command (PIX/RD/NONE) travels a 2-stage tag pipeline alongside the RAM command. It steers `ram_rdata` into `pix_data`/`pix_valid` or `rd_data`/`rd_valid`. Writes carry tag NONE.
- `pix_req` on every cycle is legal and starves writer/reader indefinitely. The timing generator guarantees this does not happen (one fetch per 4 clk during active video).
- `pix_data`/`rd_data` hold their last value when not valid.

## Timing
- Cycle t: request + grant (combinational).
- Cycle t+1: `ram_en`/`ram_we`/`ram_addr`/`ram_wdata` registered outputs.
- Cycle t+2: `ram_rdata` valid.
- Cycle t+3: `pix_valid` or `rd_valid` = 1 with data.
- Read latency from `pix_req`/`rd_gnt` to valid: exactly 3 cycles, fixed, back-to-back throughput 1 per cycle.
- Write visible to a read accepted at t+1 or later: RAM is write-first at same address. The arbiter adds no forwarding.
- Reset values (in the cycle after `rst` sampled high): `ram_en` = `ram_we` = 0, `ram_addr` = `ram_wdata` = 0, `pix_valid` = `rd_valid` = 0, `pix_data` = `rd_data` = 0, tag pipeline cleared, `last_wr` = 0 (writer wins first tie).
- While `rst` = 1: `wr_gnt` = `rd_gnt` = 0, requests ignored.
- Reset mid-operation: in-flight reads are discarded; no valid pulse ever emerges for them.
- `blank` toggling while `wr_req` is held under WR_BLANK_ONLY: the grant occurs in the first cycle with `blank` = 1 and no `pix_req`.

## Test plan
- Reset: hold `rst` 100 ns with all requests high → all outputs 0, no grants. First tie after release → `wr_gnt` before `rd_gnt`.
- Pixel latency: `pix_req` at t with `pix_addr` = 0x00123, RAM model returns 0xABC → `ram_en` = 1, `ram_addr` = 0x00123 at t+1; `pix_valid` = 1, `pix_data` = 0xABC at t+3 only.
- Priority: `pix_req`, `wr_req` and `rd_req` all high at t → only pixel served; `wr_gnt` at t+1 if `pix_req` dropped; `rd_gnt` at t+2.
- Round-robin: `wr_req` and `rd_req` held high for 6 cycles, no pixel → grants alternate W,R,W,R,W,R.
- Blank gating (WR_BLANK_ONLY = 1): `wr_req` raised with `blank` = 0 for 10 cycles → no `wr_gnt`. `blank` rises → `wr_gnt` same cycle; `ram_we` = 1 next cycle with correct address/data.
- Mid-flight reset: `rd_gnt` at t, `rst` high at t+1 → `rd_valid` stays 0 through t+5.
